cadr_clock_gen: RTL and testbench
=================================

# cadr_clock_gen

Cycle-accurate, synthesizable model of the CADR processor's machine-cycle clock generator. It covers the 74S151 cycle-length selector and the TD100/TD50/TD25 tapped delay lines, with each delay line implemented as a shift register on a 5 ns tick. It produces the active-low TPR* (read-phase) and TPW* (write-phase) timing strobes for the CPU. It free-runs one machine cycle after another unless hung or held in reset.

## Interface
Parameters:
- TICK_NS, 5: nanoseconds per clk period; every tap delay is an exact multiple of it.

Ports:
- clk  in  1  tick clock (200 MHz nominal).
- clock_reset_b  in  1  reset, asynchronous, active-low.
- hang_n  in  1  low holds off the start of the next cycle.
- ilong_n  in  1  mux SEL0; low selects the long cycle.
- sspeed  in  2  mux SEL2 = sspeed[1], SEL1 = sspeed[0].
- tpr0_n, tpr40_n, tpr60_n, tpr100_n, tpr140_n, tpr160_n  out  1 each  read taps.
- tprend_n  out  1  selected end-of-read strobe (74S151 Q).
- tprend  out  1  inverse of tprend_n (Q_N).
- tpw10_n, tpw20_n, tpw30_n, tpw50_n, tpw60_n, tpw70_n, tpw75_n  out  1 each  write taps.
- tpdone_n  out  1  equals tpw60_n.
- cycle_completed  out  1  cycle latch state.

## Operation
- tprK_n is tpr0_n delayed K/5 ticks. The internal read taps 75, 85, 115 and 125 feed the mux only.
- tpwK_n is tprend_n delayed K/5 ticks.
- 74S151 mux. Index = {sspeed[1], sspeed[0], ilong_n}. The mux is combinational and always enabled. Inputs:
  - I0 = 160, I1 = 160, I2 = 140, I3 = 100
  - I4 = 125, I5 = 85, I6 = 115, I7 = 75
- tpr0_n = ~(hang_n & clock_reset_b & cycle_completed). This is combinational.
- cycle_completed is a register:
  - Cleared on a clk edge where tpr40_n = 0.
  - Set on an edge where tpdone_n = 0 and tpr40_n = 1.
  - Otherwise it holds its value.
- Reset is asynchronous. While clock_reset_b = 0:
  - Every delay stage is forced to 1, so all tap outputs read 1.
  - cycle_completed = 1.
  - tpr0_n = 1, tprend_n = 1, tprend = 0.
- Reset asserted mid-cycle aborts the cycle immediately. No partial strobes occur after reset deasserts.
- hang_n = 0 holds tpr0_n high indefinitely, because cycle_completed stays 1. The cycle starts on the first tick hang_n is high.
- A change to sspeed or ilong_n mid-cycle takes effect combinationally on tprend_n. It may shorten, lengthen or repeat that cycle's end strobe. This is permitted.

## Timing
- Tick 0 is the first tick tpr0_n is low after a reset release, un-hang or cycle completion.
- tpr0_n is low for ticks 0–8, a 9-tick width. tprK_n is low for ticks K/5 to K/5+8.
- E denotes the selected tap in ns. tprend_n is low for ticks E/5 to E/5+8.
- tpdone_n first goes low at tick E/5+12. cycle_completed sets on that edge.
- The next tpr0_n goes low at tick E/5+13. The period is therefore E/5+13 ticks:
  - 75 → 28 ticks
  - 85 → 30 ticks
  - 100 → 33 ticks
  - 115 → 36 ticks
  - 125 → 38 ticks
  - 140 → 41 ticks
  - 160 → 45 ticks
- Every output is defined from registered state, except tpr0_n, tprend_n and tprend, which are combinational.

## Structure
- Package cadr_clock_pkg holds TICK_NS, the tap constants (read taps 40–160 and write taps 10–75, in ns) and the 8-entry mux tap table.
- Sub-module cadr_delay_line:
  - Parameterized depth; async set-to-1 on reset; taps exposed as a vector.
  - Instantiated twice: a 32-stage read chain from tpr0_n and a 15-stage write chain from tprend_n.
- The top level contains the mux, the cycle latch and the tap wiring.

## Test plan
- Reset low for 40 ticks, then release with sspeed = 11, ilong_n = 0, hang_n = 1:
  - tpr0_n falls at ticks 0, 36, 72.
  - tprend_n is low for ticks 23–31.
  - tpdone_n falls at tick 35.
- sspeed = 11, ilong_n = 1: tpr0_n period is 28 ticks and tprend_n falls at tick 15.
- Sweep all 8 mux indices: measured periods are 45, 45, 41, 33, 38, 30, 36, 28 ticks in index order 0–7.
- hang_n = 0 at tick 10, released at tick 100:
  - The current cycle finishes.
  - tpr0_n stays high until tick 100, then falls.
  - The next period is nominal.
- clock_reset_b pulsed low at tick 20:
  - All tap outputs go high immediately and cycle_completed = 1.
  - After release, a clean cycle starts at tick 0 with correct timing.
- Check tpr40_n, tpr60_n and tpr100_n trail tpr0_n by exactly 8, 12 and 20 ticks. Check tpw10_n–tpw75_n trail tprend_n by 2, 4, 6, 10, 12, 14 and 15 ticks.

Source files
------------

// File: rtl/cadr_clock_pkg.sv
// Shared timing constants for the CADR machine-cycle clock generator:
// tick length, read/write tap delays in ns and the cycle-length mux table.
package cadr_clock_pkg;

  localparam int TICK_NS = 5;

  localparam int TPR40_NS  = 40;
  localparam int TPR60_NS  = 60;
  localparam int TPR75_NS  = 75;
  localparam int TPR85_NS  = 85;
  localparam int TPR100_NS = 100;
  localparam int TPR115_NS = 115;
  localparam int TPR125_NS = 125;
  localparam int TPR140_NS = 140;
  localparam int TPR160_NS = 160;

  localparam int TPW10_NS = 10;
  localparam int TPW20_NS = 20;
  localparam int TPW30_NS = 30;
  localparam int TPW50_NS = 50;
  localparam int TPW60_NS = 60;
  localparam int TPW70_NS = 70;
  localparam int TPW75_NS = 75;

  // 74S151 inputs I0..I7, indexed by {sspeed[1], sspeed[0], ilong_n}.
  function automatic int mux_tap_ns(input int idx);
    case (idx)
      0, 1:    return TPR160_NS;
      2:       return TPR140_NS;
      3:       return TPR100_NS;
      4:       return TPR125_NS;
      5:       return TPR85_NS;
      6:       return TPR115_NS;
      default: return TPR75_NS;
    endcase
  endfunction

  // Stage 0 of a chain is already one tick behind its input.
  function automatic int tap_stage(input int tap_ns, input int tick_ns);
    return tap_ns / tick_ns - 1;
  endfunction

endpackage

// File: rtl/cadr_delay_line.sv
// Tapped delay line modelled as a shift register on the tick clock;
// taps[i] is the input delayed by i+1 ticks. Reset forces every stage high.
module cadr_delay_line #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [DEPTH-1:0] taps
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps <= '1;
    end else begin
      taps <= {taps[DEPTH-2:0], din};
    end
  end

endmodule

// File: rtl/cadr_clock_gen.sv
// CADR machine-cycle clock generator: TPR read chain, 74S151 cycle-length
// selector, TPW write chain and the cycle-completed latch.
module cadr_clock_gen
  import cadr_clock_pkg::*;
#(
  parameter int TICK_NS = cadr_clock_pkg::TICK_NS
) (
  input  logic       clk,
  input  logic       clock_reset_b,
  input  logic       hang_n,
  input  logic       ilong_n,
  input  logic [1:0] sspeed,
  output logic       tpr0_n,
  output logic       tpr40_n,
  output logic       tpr60_n,
  output logic       tpr100_n,
  output logic       tpr140_n,
  output logic       tpr160_n,
  output logic       tprend_n,
  output logic       tprend,
  output logic       tpw10_n,
  output logic       tpw20_n,
  output logic       tpw30_n,
  output logic       tpw50_n,
  output logic       tpw60_n,
  output logic       tpw70_n,
  output logic       tpw75_n,
  output logic       tpdone_n,
  output logic       cycle_completed
);

  localparam int RD_DEPTH = TPR160_NS / TICK_NS;
  localparam int WR_DEPTH = TPW75_NS / TICK_NS;

  logic [RD_DEPTH-1:0] rd_taps;
  logic [WR_DEPTH-1:0] wr_taps;
  logic [7:0]          mux_in;
  logic [2:0]          mux_sel;
  logic                unused_taps;

  // Reset gates the start strobe directly so no cycle begins while held.
  assign tpr0_n = ~(hang_n & clock_reset_b & cycle_completed);

  cadr_delay_line #(.DEPTH(RD_DEPTH)) u_read_chain (
    .clk   (clk),
    .rst_n (clock_reset_b),
    .din   (tpr0_n),
    .taps  (rd_taps)
  );

  assign tpr40_n  = rd_taps[tap_stage(TPR40_NS,  TICK_NS)];
  assign tpr60_n  = rd_taps[tap_stage(TPR60_NS,  TICK_NS)];
  assign tpr100_n = rd_taps[tap_stage(TPR100_NS, TICK_NS)];
  assign tpr140_n = rd_taps[tap_stage(TPR140_NS, TICK_NS)];
  assign tpr160_n = rd_taps[tap_stage(TPR160_NS, TICK_NS)];

  for (genvar gi = 0; gi < 8; gi++) begin : g_mux
    assign mux_in[gi] = rd_taps[tap_stage(mux_tap_ns(gi), TICK_NS)];
  end

  assign mux_sel  = {sspeed[1], sspeed[0], ilong_n};
  assign tprend_n = mux_in[mux_sel];
  assign tprend   = ~tprend_n;

  cadr_delay_line #(.DEPTH(WR_DEPTH)) u_write_chain (
    .clk   (clk),
    .rst_n (clock_reset_b),
    .din   (tprend_n),
    .taps  (wr_taps)
  );

  assign tpw10_n  = wr_taps[tap_stage(TPW10_NS, TICK_NS)];
  assign tpw20_n  = wr_taps[tap_stage(TPW20_NS, TICK_NS)];
  assign tpw30_n  = wr_taps[tap_stage(TPW30_NS, TICK_NS)];
  assign tpw50_n  = wr_taps[tap_stage(TPW50_NS, TICK_NS)];
  assign tpw60_n  = wr_taps[tap_stage(TPW60_NS, TICK_NS)];
  assign tpw70_n  = wr_taps[tap_stage(TPW70_NS, TICK_NS)];
  assign tpw75_n  = wr_taps[tap_stage(TPW75_NS, TICK_NS)];
  assign tpdone_n = tpw60_n;

  // Clearing on TPR40 wins, so a late TPDONE cannot re-arm the current cycle.
  always_ff @(posedge clk or negedge clock_reset_b) begin
    if (!clock_reset_b) begin
      cycle_completed <= 1'b1;
    end else if (!tpr40_n) begin
      cycle_completed <= 1'b0;
    end else if (!tpdone_n) begin
      cycle_completed <= 1'b1;
    end
  end

  assign unused_taps = ^{rd_taps, wr_taps};

endmodule

// File: tb/tb_cadr_clock_gen.sv
// Directed bench for cadr_clock_gen: captures per-tick output traces and
// checks edge positions against hand-computed tick numbers.
module tb_cadr_clock_gen;

  localparam int S_TPR0   = 0;
  localparam int S_TPR40  = 1;
  localparam int S_TPR60  = 2;
  localparam int S_TPR100 = 3;
  localparam int S_TPR140 = 4;
  localparam int S_TPR160 = 5;
  localparam int S_END    = 6;
  localparam int S_ENDP   = 7;
  localparam int S_W10    = 8;
  localparam int S_DONE   = 15;
  localparam int S_CC     = 16;
  localparam int RESET_PACK = 'h1FF7F;

  logic       clk = 1'b0;
  logic       clock_reset_b = 1'b0;
  logic       hang_n = 1'b1;
  logic       ilong_n = 1'b0;
  logic [1:0] sspeed = 2'b11;
  logic tpr0_n, tpr40_n, tpr60_n, tpr100_n, tpr140_n, tpr160_n;
  logic tprend_n, tprend;
  logic tpw10_n, tpw20_n, tpw30_n, tpw50_n, tpw60_n, tpw70_n, tpw75_n;
  logic tpdone_n, cycle_completed;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cap   = 0;
  logic [16:0] trace [0:159];

  int exp_period [8] = '{45, 45, 41, 33, 38, 30, 36, 28};
  int exp_end    [8] = '{32, 32, 28, 20, 25, 17, 23, 15};
  int exp_wdelay [7] = '{2, 4, 6, 10, 12, 14, 15};

  cadr_clock_gen dut (
    .clk             (clk),
    .clock_reset_b   (clock_reset_b),
    .hang_n          (hang_n),
    .ilong_n         (ilong_n),
    .sspeed          (sspeed),
    .tpr0_n          (tpr0_n),
    .tpr40_n         (tpr40_n),
    .tpr60_n         (tpr60_n),
    .tpr100_n        (tpr100_n),
    .tpr140_n        (tpr140_n),
    .tpr160_n        (tpr160_n),
    .tprend_n        (tprend_n),
    .tprend          (tprend),
    .tpw10_n         (tpw10_n),
    .tpw20_n         (tpw20_n),
    .tpw30_n         (tpw30_n),
    .tpw50_n         (tpw50_n),
    .tpw60_n         (tpw60_n),
    .tpw70_n         (tpw70_n),
    .tpw75_n         (tpw75_n),
    .tpdone_n        (tpdone_n),
    .cycle_completed (cycle_completed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] pack();
    return {cycle_completed, tpdone_n, tpw75_n, tpw70_n, tpw60_n, tpw50_n,
            tpw30_n, tpw20_n, tpw10_n, tprend, tprend_n, tpr160_n, tpr140_n,
            tpr100_n, tpr60_n, tpr40_n, tpr0_n};
  endfunction

  // First tick at or after 'from' where signal s reaches level lvl.
  function automatic int next_edge(input int s, input int from, input logic lvl);
    for (int t = from; t < n_cap; t++) begin
      if (trace[t][s] == lvl && (t == 0 || trace[t-1][s] != lvl)) return t;
    end
    return -1;
  endfunction

  // Hold reset a few ticks with the given mux index, release on a negedge.
  task automatic start(input logic [2:0] idx);
    @(negedge clk);
    clock_reset_b = 1'b0;
    hang_n  = 1'b1;
    sspeed  = idx[2:1];
    ilong_n = idx[0];
    repeat (3) @(negedge clk);
    clock_reset_b = 1'b1;
  endtask

  // Tick 0 is sampled right after release; later ticks just after each negedge.
  task automatic capture(input int n, input int hang_lo, input int hang_hi,
                         input int rst_at);
    n_cap = n;
    for (int t = 0; t < n; t++) begin
      if (t > 0) @(negedge clk);
      if (t == hang_lo) hang_n = 1'b0;
      if (t == hang_hi) hang_n = 1'b1;
      if (t == rst_at)  clock_reset_b = 1'b0;
      #1;
      trace[t] = pack();
    end
  endtask

  initial begin
    int f0, f1, e0;

    // Power-on reset: 40 ticks low, sspeed=11, ilong_n=0 (115 ns tap)
    repeat (20) @(negedge clk);
    #1;
    check("reset_outputs", int'(pack()), RESET_PACK);
    repeat (20) @(negedge clk);
    clock_reset_b = 1'b1;
    capture(110, -1, -1, -1);
    $display("[TB] txn: release idx6 traced %0d ticks", n_cap);
    check("tpr0_fall0", next_edge(S_TPR0, 0, 1'b0), 0);
    check("tpr0_width", next_edge(S_TPR0, 1, 1'b1), 9);
    check("tpr0_fall1", next_edge(S_TPR0, 1, 1'b0), 36);
    check("tpr0_fall2", next_edge(S_TPR0, 37, 1'b0), 72);
    check("tprend_fall", next_edge(S_END, 0, 1'b0), 23);
    check("tprend_rise", next_edge(S_END, 24, 1'b1), 32);
    check("tprend_pos", int'(trace[23][S_ENDP]), 1);
    check("tpdone_fall", next_edge(S_DONE, 0, 1'b0), 35);
    check("cc_tick8", int'(trace[8][S_CC]), 1);
    check("cc_tick9", int'(trace[9][S_CC]), 0);
    check("cc_tick36", int'(trace[36][S_CC]), 1);
    check("tpr40_lag", next_edge(S_TPR40, 0, 1'b0), 8);
    check("tpr60_lag", next_edge(S_TPR60, 0, 1'b0), 12);
    check("tpr100_lag", next_edge(S_TPR100, 0, 1'b0), 20);
    check("tpr140_lag", next_edge(S_TPR140, 0, 1'b0), 28);
    check("tpr160_lag", next_edge(S_TPR160, 0, 1'b0), 32);
    for (int w = 0; w < 7; w++) begin
      check($sformatf("tpw%0d_lag", w), next_edge(S_W10 + w, 0, 1'b0) - 23,
            exp_wdelay[w]);
    end

    // Sweep every mux index from a clean reset
    for (int i = 0; i < 8; i++) begin
      logic [2:0] idx;
      idx = 3'(i);
      start(idx);
      capture(60, -1, -1, -1);
      f0 = next_edge(S_TPR0, 0, 1'b0);
      f1 = next_edge(S_TPR0, 1, 1'b0);
      e0 = next_edge(S_END, 0, 1'b0);
      $display("[TB] txn: idx %0d tpr0 falls %0d,%0d tprend falls %0d", i, f0, f1, e0);
      check($sformatf("sweep%0d_first", i), f0, 0);
      check($sformatf("sweep%0d_period", i), f1 - f0, exp_period[i]);
      check($sformatf("sweep%0d_tprend", i), e0, exp_end[i]);
    end

    // Hang from tick 10 to tick 100
    start(3'd6);
    capture(140, 10, 100, -1);
    $display("[TB] txn: hang 10..100 traced %0d ticks", n_cap);
    check("hang_tprend", next_edge(S_END, 0, 1'b0), 23);
    check("hang_tpdone", next_edge(S_DONE, 0, 1'b0), 35);
    check("hang_cc", int'(trace[60][S_CC]), 1);
    check("hang_restart", next_edge(S_TPR0, 1, 1'b0), 100);
    check("hang_next", next_edge(S_TPR0, 101, 1'b0), 136);

    // Reset pulse at tick 20 aborts the cycle mid-strobe
    start(3'd6);
    capture(21, -1, -1, 20);
    $display("[TB] txn: reset pulse at tick 20");
    check("pulse_pre_tpr60", int'(trace[19][S_TPR60]), 0);
    check("pulse_pre_cc", int'(trace[19][S_CC]), 0);
    check("pulse_outputs", int'(trace[20]), RESET_PACK);
    repeat (4) @(negedge clk);
    clock_reset_b = 1'b1;
    capture(40, -1, -1, -1);
    $display("[TB] txn: release after pulse traced %0d ticks", n_cap);
    check("pulse_fall0", next_edge(S_TPR0, 0, 1'b0), 0);
    check("pulse_tpr60", next_edge(S_TPR60, 0, 1'b0), 12);
    check("pulse_tprend", next_edge(S_END, 0, 1'b0), 23);
    check("pulse_fall1", next_edge(S_TPR0, 1, 1'b0), 36);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
